// File: rtl/lcd_timing_if.sv
// Pixel-side bundle between the LCD timing generator, the overlay renderer and the panel pins.
interface lcd_timing_if;
    logic [23:0] pixel_data;
    logic [10:0] pixel_xpos;
    logic [10:0] pixel_ypos;
    logic        lcd_hs;
    logic        lcd_vs;
    logic        lcd_de;
    logic [23:0] lcd_rgb;
    logic        frame_start;

    modport master (
        input  pixel_data,
        output pixel_xpos, pixel_ypos, lcd_hs, lcd_vs, lcd_de, lcd_rgb, frame_start
    );

    modport slave (
        output pixel_data,
        input  pixel_xpos, pixel_ypos, lcd_hs, lcd_vs, lcd_de, lcd_rgb, frame_start
    );
endinterface

// File: rtl/lcd_timing_gen.sv
// Parallel-RGB LCD timing generator: free-running H/V counters request pixels one cycle
// ahead, and sync/enable are registered so they line up with the renderer's returned data.
module lcd_timing_gen #(
    parameter int H_SYNC  = 41,
    parameter int H_BACK  = 2,
    parameter int H_DISP  = 480,
    parameter int H_FRONT = 2,
    parameter int V_SYNC  = 10,
    parameter int V_BACK  = 2,
    parameter int V_DISP  = 272,
    parameter int V_FRONT = 2
) (
    input  logic          lcd_pclk,
    input  logic          sys_rst_n,
    lcd_timing_if.master  lcd
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
    // The request window opens one count early so the renderer's register delay is absorbed.
    localparam logic [10:0] HA     = 11'(H_SYNC + H_BACK - 1);
    localparam logic [10:0] HA_END = 11'(H_SYNC + H_BACK - 1 + H_DISP);
    localparam logic [10:0] VA     = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] VA_END = 11'(V_SYNC + V_BACK + V_DISP);
    localparam logic [10:0] HS_END = 11'(H_SYNC);
    localparam logic [10:0] VS_END = 11'(V_SYNC);

    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic        h_req;
    logic        v_act;
    logic        req;
    logic        de_q;
    logic        hs_q;
    logic        vs_q;
    logic        fs_q;

    always_ff @(posedge lcd_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_cnt <= 11'd0;
            v_cnt <= 11'd0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= 11'd0;
            v_cnt <= (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
        end else begin
            h_cnt <= h_cnt + 11'd1;
        end
    end

    always_comb begin
        h_req = (h_cnt >= HA) && (h_cnt < HA_END);
        v_act = (v_cnt >= VA) && (v_cnt < VA_END);
        req   = h_req && v_act;
    end

    always_ff @(posedge lcd_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            de_q <= 1'b0;
            hs_q <= 1'b1;
            vs_q <= 1'b1;
            fs_q <= 1'b0;
        end else begin
            de_q <= req;
            hs_q <= ~(h_cnt < HS_END);
            vs_q <= ~(v_cnt < VS_END);
            fs_q <= (h_cnt == 11'd0) && (v_cnt == 11'd0);
        end
    end

    assign lcd.pixel_xpos  = req ? (h_cnt - HA) : 11'd0;
    assign lcd.pixel_ypos  = req ? (v_cnt - VA) : 11'd0;
    assign lcd.lcd_de      = de_q;
    assign lcd.lcd_hs      = hs_q;
    assign lcd.lcd_vs      = vs_q;
    assign lcd.frame_start = fs_q;
    // Blanking is forced black regardless of what the renderer returns.
    assign lcd.lcd_rgb     = de_q ? lcd.pixel_data : 24'h0;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: a full-size instance for line/pixel timing and a shrunken
// instance so whole frames, mid-frame reset and the last pixel fit in a short run.
module tb_lcd_timing_gen;

    typedef struct packed {
        int hs; int hb; int hd; int hf;
        int vs; int vb; int vd; int vf;
    } timing_t;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic [23:0] rgb;
    } exp_t;

    localparam timing_t PA = '{hs:41, hb:2, hd:480, hf:2, vs:10, vb:2, vd:272, vf:2};
    localparam timing_t PB = '{hs:4,  hb:2, hd:16,  hf:2, vs:3,  vb:2, vd:8,   vf:2};
    localparam exp_t    RST = '{x:11'd0, y:11'd0, hs:1'b1, vs:1'b1, de:1'b0, fs:1'b0, rgb:24'h0};

    logic        lcd_pclk = 1'b0;
    logic        sys_rst_n = 1'b0;
    longint      k;
    logic [23:0] pd_a;
    logic [23:0] pd_b;
    int          tests_run = 0;
    int          tests_failed = 0;

    lcd_timing_if if_a ();
    lcd_timing_if if_b ();

    lcd_timing_gen dut_a (
        .lcd_pclk  (lcd_pclk),
        .sys_rst_n (sys_rst_n),
        .lcd       (if_a)
    );

    lcd_timing_gen #(
        .H_SYNC(PB.hs), .H_BACK(PB.hb), .H_DISP(PB.hd), .H_FRONT(PB.hf),
        .V_SYNC(PB.vs), .V_BACK(PB.vb), .V_DISP(PB.vd), .V_FRONT(PB.vf)
    ) dut_b (
        .lcd_pclk  (lcd_pclk),
        .sys_rst_n (sys_rst_n),
        .lcd       (if_b)
    );

    assign if_a.pixel_data = pd_a;
    assign if_b.pixel_data = pd_b;

    always #5 lcd_pclk = ~lcd_pclk;

    // Reference model: cycle k after reset release maps to a raster position by plain division.
    function automatic int hc_of(timing_t p, longint kk);
        longint ht = longint'(p.hs + p.hb + p.hd + p.hf);
        return int'(kk % ht);
    endfunction

    function automatic int vc_of(timing_t p, longint kk);
        longint ht = longint'(p.hs + p.hb + p.hd + p.hf);
        longint vt = longint'(p.vs + p.vb + p.vd + p.vf);
        return int'((kk / ht) % vt);
    endfunction

    function automatic bit req_of(timing_t p, longint kk);
        int ha = p.hs + p.hb - 1;
        int va = p.vs + p.vb;
        int hc = hc_of(p, kk);
        int vc = vc_of(p, kk);
        return (hc >= ha) && (hc < ha + p.hd) && (vc >= va) && (vc < va + p.vd);
    endfunction

    function automatic exp_t model_out(timing_t p, longint kk);
        exp_t   e;
        int     ha = p.hs + p.hb - 1;
        int     va = p.vs + p.vb;
        longint fr = longint'(p.hs + p.hb + p.hd + p.hf) * longint'(p.vs + p.vb + p.vd + p.vf);
        e = '0;
        if (req_of(p, kk)) begin
            e.x = 11'(hc_of(p, kk) - ha);
            e.y = 11'(vc_of(p, kk) - va);
        end
        if (kk == 0) begin
            e.hs = 1'b1;
            e.vs = 1'b1;
        end else begin
            e.hs = (hc_of(p, kk - 1) >= p.hs);
            e.vs = (vc_of(p, kk - 1) >= p.vs);
            e.de = req_of(p, kk - 1);
            e.fs = ((kk - 1) % fr) == 0;
            if (e.de) e.rgb = {11'(vc_of(p, kk - 1) - va), 2'b00, 11'(hc_of(p, kk - 1) - ha)};
        end
        return e;
    endfunction

    function automatic exp_t got_a();
        exp_t g;
        g.x = if_a.pixel_xpos; g.y = if_a.pixel_ypos; g.hs = if_a.lcd_hs; g.vs = if_a.lcd_vs;
        g.de = if_a.lcd_de; g.fs = if_a.frame_start; g.rgb = if_a.lcd_rgb;
        return g;
    endfunction

    function automatic exp_t got_b();
        exp_t g;
        g.x = if_b.pixel_xpos; g.y = if_b.pixel_ypos; g.hs = if_b.lcd_hs; g.vs = if_b.lcd_vs;
        g.de = if_b.lcd_de; g.fs = if_b.frame_start; g.rgb = if_b.lcd_rgb;
        return g;
    endfunction

    // Renderer stand-in: returns {y,2'b0,x} one cycle later, random garbage for non-requests.
    always @(posedge lcd_pclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            k    <= 0;
            pd_a <= 24'h0;
            pd_b <= 24'h0;
        end else begin
            k    <= k + 1;
            pd_a <= {if_a.pixel_ypos, 2'b00, if_a.pixel_xpos} ^
                    (req_of(PA, k) ? 24'h0 : (24'($urandom) | 24'h1));
            pd_b <= {if_b.pixel_ypos, 2'b00, if_b.pixel_xpos} ^
                    (req_of(PB, k) ? 24'h0 : (24'($urandom) | 24'h1));
        end
    end

    task automatic test_reset();
        exp_t   ga, gb;
        int     hs_low = 0;
        longint first_low = -1;
        int     fs_first = 0;
        int     fs_other = 0;
        sys_rst_n = 1'b0;
        repeat (3) @(negedge lcd_pclk);
        ga = got_a(); gb = got_b();
        tests_run++;
        if (ga !== RST) begin
            tests_failed++; $display("[TB] FAIL reset_a: got %h, want %h", ga, RST);
        end
        tests_run++;
        if (gb !== RST) begin
            tests_failed++; $display("[TB] FAIL reset_b: got %h, want %h", gb, RST);
        end
        sys_rst_n = 1'b1;
        #1;
        ga = got_a();
        tests_run++;
        if (ga !== RST) begin
            tests_failed++; $display("[TB] FAIL release_a: got %h, want %h", ga, RST);
        end
        repeat (45) begin
            @(negedge lcd_pclk);
            if (!if_a.lcd_hs) begin
                hs_low++;
                if (first_low < 0) first_low = k;
            end
            if (if_a.frame_start) begin
                if (k == 1) fs_first++; else fs_other++;
            end
        end
        tests_run++;
        if (hs_low !== 41) begin
            tests_failed++; $display("[TB] FAIL hsync_width: got %0d, want 41", hs_low);
        end
        tests_run++;
        if (first_low !== 64'sd1) begin
            tests_failed++; $display("[TB] FAIL hsync_start: got %0d, want 1", first_low);
        end
        tests_run++;
        if (fs_first !== 1 || fs_other !== 0) begin
            tests_failed++;
            $display("[TB] FAIL first_frame_start: got %0d at k=1 and %0d elsewhere, want 1 and 0", fs_first, fs_other);
        end
    endtask

    task automatic test_active_line();
        exp_t   ga, e, bad_g, bad_e;
        int     bad = 0;
        int     de_cnt = 0;
        longint first_de = -1;
        longint last_de = -1;
        longint bad_k = -1;
        logic [10:0] x_first = 11'h7FF;
        logic [10:0] x_last = 11'h7FF;
        longint base = 12 * 525;
        bad_g = '0; bad_e = '0;
        while (k < base) @(negedge lcd_pclk);
        repeat (527) begin
            ga = got_a(); e = model_out(PA, k);
            if (ga !== e) begin
                if (bad == 0) begin bad_k = k; bad_g = ga; bad_e = e; end
                bad++;
            end
            if (ga.de) begin
                de_cnt++;
                if (first_de < 0) first_de = k;
                last_de = k;
            end
            if (k == base + 42) x_first = ga.x;
            if (k == base + 521) x_last = ga.x;
            @(negedge lcd_pclk);
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++;
            $display("[TB] FAIL line12_model: got %0d bad cycles (first k=%0d got %h want %h), want 0", bad, bad_k, bad_g, bad_e);
        end
        tests_run++;
        if (de_cnt !== 480) begin
            tests_failed++; $display("[TB] FAIL line12_de_count: got %0d, want 480", de_cnt);
        end
        tests_run++;
        if (first_de !== base + 43 || last_de !== base + 522) begin
            tests_failed++;
            $display("[TB] FAIL line12_de_window: got %0d..%0d, want %0d..%0d", first_de, last_de, base + 43, base + 522);
        end
        tests_run++;
        if (x_first !== 11'd0 || x_last !== 11'd479) begin
            tests_failed++; $display("[TB] FAIL line12_xpos_span: got %0d..%0d, want 0..479", x_first, x_last);
        end
    endtask

    task automatic test_render();
        exp_t   ga, e;
        int     bad_rgb = 0;
        int     blank_dirty = 0;
        int     de_cnt = 0;
        repeat (3 * 525) begin
            ga = got_a(); e = model_out(PA, k);
            if (ga.de) begin
                de_cnt++;
                if (ga.rgb !== e.rgb) bad_rgb++;
            end else if (ga.rgb !== 24'h0) begin
                blank_dirty++;
            end
            @(negedge lcd_pclk);
        end
        tests_run++;
        if (bad_rgb !== 0) begin
            tests_failed++; $display("[TB] FAIL render_rgb: got %0d wrong pixels, want 0", bad_rgb);
        end
        tests_run++;
        if (blank_dirty !== 0) begin
            tests_failed++; $display("[TB] FAIL blank_black: got %0d nonzero blank cycles, want 0", blank_dirty);
        end
        tests_run++;
        if (de_cnt !== 1440) begin
            tests_failed++; $display("[TB] FAIL render_de_count: got %0d, want 1440", de_cnt);
        end
    endtask

    task automatic test_full_frame();
        exp_t ga, e;
        int   wait_cnt = 0;
        int   period = 0;
        int   de_cnt = 0;
        int   vs_low = 0;
        int   bad = 0;
        while (!if_b.frame_start && wait_cnt < 400) begin
            @(negedge lcd_pclk);
            wait_cnt++;
        end
        tests_run++;
        if (!if_b.frame_start) begin
            tests_failed++; $display("[TB] FAIL frame_start_seen: got 0, want 1 within 400 cycles");
            return;
        end
        do begin
            ga = got_b(); e = model_out(PB, k);
            if (ga !== e) bad++;
            if (ga.de) de_cnt++;
            if (!ga.vs) vs_low++;
            @(negedge lcd_pclk);
            period++;
        end while (!if_b.frame_start && period < 800);
        tests_run++;
        if (period !== 360) begin
            tests_failed++; $display("[TB] FAIL frame_period: got %0d, want 360", period);
        end
        tests_run++;
        if (de_cnt !== 128) begin
            tests_failed++; $display("[TB] FAIL frame_de_count: got %0d, want 128", de_cnt);
        end
        tests_run++;
        if (vs_low !== 72) begin
            tests_failed++; $display("[TB] FAIL vsync_width: got %0d, want 72", vs_low);
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++; $display("[TB] FAIL frame_model: got %0d bad cycles, want 0", bad);
        end
    endtask

    task automatic test_mid_reset();
        exp_t   ga, gb;
        int     target = 6 * 24 + int'($urandom_range(0, 23));
        int     wait_cnt = 0;
        int     rst_bad = 0;
        int     bad_a = 0;
        int     bad_b = 0;
        int     early_a = 0;
        int     early_b = 0;
        longint first_a = -1;
        longint first_b = -1;
        while ((k % 360) != longint'(target) && wait_cnt < 400) begin
            @(negedge lcd_pclk);
            wait_cnt++;
        end
        sys_rst_n = 1'b0;
        #1;
        repeat (3) begin
            if (got_a() !== RST || got_b() !== RST) rst_bad++;
            @(negedge lcd_pclk);
        end
        tests_run++;
        if (rst_bad !== 0) begin
            tests_failed++; $display("[TB] FAIL mid_reset_values: got %0d bad cycles, want 0", rst_bad);
        end
        sys_rst_n = 1'b1;
        while (k <= 6344) begin
            ga = got_a(); gb = got_b();
            if (ga !== model_out(PA, k)) bad_a++;
            if (gb !== model_out(PB, k)) bad_b++;
            if (ga.de) begin
                if (first_a < 0) first_a = k;
                if (k <= 12 * 525) early_a++;
            end
            if (gb.de) begin
                if (first_b < 0) first_b = k;
                if (k <= 5 * 24) early_b++;
            end
            @(negedge lcd_pclk);
        end
        tests_run++;
        if (first_a !== 64'sd6343 || early_a !== 0) begin
            tests_failed++;
            $display("[TB] FAIL restart_a_first_de: got k=%0d (%0d early), want k=6343 (0 early)", first_a, early_a);
        end
        tests_run++;
        if (first_b !== 64'sd126 || early_b !== 0) begin
            tests_failed++;
            $display("[TB] FAIL restart_b_first_de: got k=%0d (%0d early), want k=126 (0 early)", first_b, early_b);
        end
        tests_run++;
        if (bad_a !== 0 || bad_b !== 0) begin
            tests_failed++; $display("[TB] FAIL restart_model: got %0d/%0d bad cycles, want 0/0", bad_a, bad_b);
        end
    endtask

    task automatic test_last_pixel();
        exp_t        gb;
        int          wait_cnt = 0;
        int          bad = 0;
        int          late = 0;
        longint      off;
        logic [21:0] xy_last = '1;
        logic [1:0]  de_edge = 2'b00;
        while ((k % 360) != 0 && wait_cnt < 400) begin
            @(negedge lcd_pclk);
            wait_cnt++;
        end
        repeat (360) begin
            gb = got_b();
            off = k % 360;
            if (gb !== model_out(PB, k)) bad++;
            if (off == 308) xy_last = {gb.x, gb.y};
            if (off == 309) de_edge[1] = gb.de;
            if (off == 310) de_edge[0] = gb.de;
            if (off >= 312 && (gb.de || gb.x != 0 || gb.y != 0)) late++;
            @(negedge lcd_pclk);
        end
        tests_run++;
        if (xy_last !== {11'd15, 11'd7}) begin
            tests_failed++;
            $display("[TB] FAIL last_pixel_xy: got (%0d,%0d), want (15,7)", xy_last[21:11], xy_last[10:0]);
        end
        tests_run++;
        if (de_edge !== 2'b10) begin
            tests_failed++; $display("[TB] FAIL last_pixel_de: got %b, want 10", de_edge);
        end
        tests_run++;
        if (late !== 0) begin
            tests_failed++; $display("[TB] FAIL post_active_idle: got %0d busy cycles, want 0", late);
        end
        tests_run++;
        if (bad !== 0) begin
            tests_failed++; $display("[TB] FAIL last_frame_model: got %0d bad cycles, want 0", bad);
        end
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_active_line();
        test_render();
        test_full_frame();
        test_mid_reset();
        test_last_pixel();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
